// File: rtl/weight_mem.sv
// -----------------------------------------------------------------------------
// weight_mem: synchronous weight store for the neural-network datapath.
//
// Holds DEPTH signed DATA_W-bit weights. After reset, and again on request, a
// hardware sweep fills the array with zeros or LFSR-derived random values.
// While idle, a valid/ready request port serves reads (latency 1), writes, and
// saturating in-place accumulates (read-modify-write, one per two cycles).
//
// Ports:
//   Clock       rising-edge clock
//   Rst         asynchronous active-low reset
//   init_start  pulse in IDLE: start an init sweep (wins over req_valid)
//   init_mode   sampled with init_start: 0 = zero fill, 1 = random fill
//   busy        high while an init sweep runs
//   init_done   one-cycle pulse after the last sweep write
//   req_valid   request present
//   req_ready   request accepted on this cycle's rising edge if req_valid
//   req_op      00 read, 01 write, 10 accumulate, 11 read
//   req_addr    word address
//   req_data    signed write data or accumulate delta
//   rd_valid    one-cycle pulse: rd_data valid
//   rd_data     signed read / accumulate result (held between pulses)
//   sat_flag    pulses with rd_valid when an accumulate was clamped
//   addr_err    pulses the cycle after accepting a request with addr >= DEPTH
// -----------------------------------------------------------------------------
module weight_mem #(
    parameter int          DATA_W     = 10,
    parameter int          DEPTH      = 65,
    parameter int          ADDR_W     = 7,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    parameter int          RAND_SHIFT = 3
) (
    input  logic                     Clock,
    input  logic                     Rst,
    input  logic                     init_start,
    input  logic                     init_mode,
    output logic                     busy,
    output logic                     init_done,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [1:0]               req_op,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic signed [DATA_W-1:0] req_data,
    output logic                     rd_valid,
    output logic signed [DATA_W-1:0] rd_data,
    output logic                     sat_flag,
    output logic                     addr_err
);

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_RMW} state_t;

    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_ACC   = 2'b10;

    localparam logic [ADDR_W:0]        DEPTH_EXT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0]      LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic signed [DATA_W:0] SUM_MAX   = (DATA_W+1)'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [DATA_W:0] SUM_MIN   = -((DATA_W+1)'(2 ** (DATA_W - 1)));

    state_t                     state_q, state_d;
    logic [ADDR_W-1:0]          ptr_q, ptr_d;
    logic                       mode_q, mode_d;
    logic [15:0]                lfsr_q, lfsr_d;
    logic [ADDR_W-1:0]          acc_addr_q, acc_addr_d;
    logic signed [DATA_W-1:0]   acc_delta_q, acc_delta_d;
    logic                       rd_valid_q, rd_valid_d;
    logic signed [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                       sat_q, sat_d;
    logic                       addr_err_q, addr_err_d;
    logic                       init_done_q, init_done_d;

    logic signed [DATA_W-1:0]   mem [DEPTH];
    logic                       mem_we;
    logic [ADDR_W-1:0]          mem_waddr;
    logic signed [DATA_W-1:0]   mem_wdata;

    logic                       req_in_range, acc_in_range;
    logic [15:0]                lfsr_next;
    logic signed [DATA_W-1:0]   rand_raw, rand_val;
    logic signed [DATA_W-1:0]   rmw_old;
    logic signed [DATA_W:0]     rmw_sum;
    logic signed [DATA_W-1:0]   rmw_clamped;
    logic                       rmw_sat;

    assign req_in_range = {1'b0, req_addr} < DEPTH_EXT;
    assign acc_in_range = {1'b0, acc_addr_q} < DEPTH_EXT;

    // Fibonacci LFSR, taps 16,14,13,11, shifting left into bit 0.
    assign lfsr_next = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign rand_raw  = lfsr_q[DATA_W-1:0];
    assign rand_val  = rand_raw >>> RAND_SHIFT;

    // One extra bit of headroom makes overflow visible before clamping.
    assign rmw_old = acc_in_range ? mem[acc_addr_q] : '0;
    assign rmw_sum = {rmw_old[DATA_W-1], rmw_old} + {acc_delta_q[DATA_W-1], acc_delta_q};

    always_comb begin
        rmw_sat     = 1'b1;
        rmw_clamped = rmw_sum[DATA_W-1:0];
        if (rmw_sum > SUM_MAX) begin
            rmw_clamped = SUM_MAX[DATA_W-1:0];
        end else if (rmw_sum < SUM_MIN) begin
            rmw_clamped = SUM_MIN[DATA_W-1:0];
        end else begin
            rmw_sat = 1'b0;
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the case below can leave a signal unassigned (no latches).
        state_d     = state_q;
        ptr_d       = ptr_q;
        mode_d      = mode_q;
        lfsr_d      = lfsr_q;
        acc_addr_d  = acc_addr_q;
        acc_delta_d = acc_delta_q;
        rd_valid_d  = 1'b0;
        rd_data_d   = rd_data_q;
        sat_d       = 1'b0;
        addr_err_d  = 1'b0;
        init_done_d = 1'b0;
        req_ready   = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = ptr_q;
        mem_wdata   = '0;

        case (state_q)
            ST_INIT: begin
                mem_we    = 1'b1;
                mem_waddr = ptr_q;
                if (mode_q) begin
                    mem_wdata = rand_val;
                    lfsr_d    = lfsr_next;
                end
                if (ptr_q == LAST_ADDR) begin
                    state_d     = ST_IDLE;
                    init_done_d = 1'b1;
                    ptr_d       = '0;
                end else begin
                    ptr_d = ptr_q + ADDR_W'(1);
                end
            end

            ST_IDLE: begin
                if (init_start) begin
                    // The sweep wins; req_ready stays low so nothing is accepted.
                    state_d = ST_INIT;
                    mode_d  = init_mode;
                    ptr_d   = '0;
                end else begin
                    req_ready = 1'b1;
                    if (req_valid) begin
                        addr_err_d = !req_in_range;
                        case (req_op)
                            OP_WRITE: begin
                                mem_we    = req_in_range;
                                mem_waddr = req_addr;
                                mem_wdata = req_data;
                            end
                            OP_ACC: begin
                                acc_addr_d  = req_addr;
                                acc_delta_d = req_data;
                                state_d     = ST_RMW;
                            end
                            default: begin  // read, and reserved op as read
                                rd_valid_d = 1'b1;
                                rd_data_d  = req_in_range ? mem[req_addr] : '0;
                            end
                        endcase
                    end
                end
            end

            ST_RMW: begin
                state_d    = ST_IDLE;
                rd_valid_d = 1'b1;
                if (acc_in_range) begin
                    mem_we    = 1'b1;
                    mem_waddr = acc_addr_q;
                    mem_wdata = rmw_clamped;
                    rd_data_d = rmw_clamped;
                    sat_d     = rmw_sat;
                end else begin
                    rd_data_d = '0;
                end
            end

            default: state_d = ST_INIT;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop.
    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            state_q     <= ST_INIT;
            ptr_q       <= '0;
            mode_q      <= 1'b0;
            lfsr_q      <= LFSR_SEED;
            acc_addr_q  <= '0;
            acc_delta_q <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            sat_q       <= 1'b0;
            addr_err_q  <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            mode_q      <= mode_d;
            lfsr_q      <= lfsr_d;
            acc_addr_q  <= acc_addr_d;
            acc_delta_q <= acc_delta_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            sat_q       <= sat_d;
            addr_err_q  <= addr_err_d;
            init_done_q <= init_done_d;
        end
    end

    // NOTE: the array has no reset; the post-reset zero sweep clears it, which
    // keeps it mappable onto RAM primitives.
    always_ff @(posedge Clock) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign busy      = (state_q == ST_INIT);
    assign init_done = init_done_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign sat_flag  = sat_q;
    assign addr_err  = addr_err_q;

endmodule

// File: tb/tb_weight_mem.sv
// -----------------------------------------------------------------------------
// tb_weight_mem: scoreboard bench for weight_mem. Inputs change on the falling
// edge; expected read results are queued at acceptance and compared whenever
// rd_valid is seen just after a rising edge.
// -----------------------------------------------------------------------------
module tb_weight_mem;

    localparam int DATA_W = 10;
    localparam int DEPTH  = 65;
    localparam int ADDR_W = 7;

    localparam logic [1:0] OP_RD  = 2'b00;
    localparam logic [1:0] OP_WR  = 2'b01;
    localparam logic [1:0] OP_ACC = 2'b10;

    logic                     Clock = 1'b0;
    logic                     Rst;
    logic                     init_start, init_mode;
    logic                     busy, init_done;
    logic                     req_valid, req_ready;
    logic [1:0]               req_op;
    logic [ADDR_W-1:0]        req_addr;
    logic signed [DATA_W-1:0] req_data;
    logic                     rd_valid;
    logic signed [DATA_W-1:0] rd_data;
    logic                     sat_flag, addr_err;

    typedef struct {
        int data;
        bit sat;
        bit rng;
    } exp_t;

    exp_t        sb[$];
    int          model_mem [DEPTH];
    logic [15:0] model_lfsr = 16'hACE1;
    int          n_checks   = 0;
    int          n_pass     = 0;

    weight_mem #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
        .LFSR_SEED(16'hACE1), .RAND_SHIFT(3)
    ) dut (
        .Clock(Clock), .Rst(Rst),
        .init_start(init_start), .init_mode(init_mode),
        .busy(busy), .init_done(init_done),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_addr(req_addr), .req_data(req_data),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .sat_flag(sat_flag), .addr_err(addr_err)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input int observed, input int expected);
        n_checks++;
        if (observed == expected) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    task automatic model_fill(input bit random);
        logic signed [DATA_W-1:0] raw;
        for (int i = 0; i < DEPTH; i++) begin
            if (random) begin
                raw          = model_lfsr[DATA_W-1:0];
                model_mem[i] = int'(raw >>> 3);
                model_lfsr   = lfsr_step(model_lfsr);
            end else begin
                model_mem[i] = 0;
            end
        end
    endtask

    // Scoreboard consumer.
    initial begin
        exp_t e;
        forever begin
            @(posedge Clock);
            #1;
            if (rd_valid) begin
                if (sb.size() == 0) begin
                    check("rd_unexpected", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("rd_data", int'(rd_data), e.data);
                    check("sat_flag", int'(sat_flag), int'(e.sat));
                    if (e.rng) check("rand_range", int'(rd_data >= -64 && rd_data <= 63), 1);
                end
            end
        end
    end

    // Counts busy cycles and init_done pulses from the current falling edge.
    task automatic wait_init(input string tag);
        int busy_cnt = 0;
        int done_cnt = 0;
        int cyc      = 0;
        while (busy && cyc < 500) begin
            busy_cnt++;
            @(negedge Clock);
            cyc++;
            if (init_done) done_cnt++;
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge Clock);
            if (init_done) done_cnt++;
        end
        check({tag, "_busy_cycles"}, busy_cnt, DEPTH);
        check({tag, "_done_pulses"}, done_cnt, 1);
    endtask

    // Drives one request at a falling edge and waits (bounded) for acceptance.
    // Returns at the falling edge after the accepting rising edge.
    task automatic send(input logic [1:0] op, input int addr, input int data, input bit rng = 0);
        int   budget = 0;
        bit   in_rng;
        int   sum;
        exp_t e;
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = ADDR_W'(addr);
        req_data  = DATA_W'(data);
        #1;
        while (!req_ready && budget < 20) begin
            @(negedge Clock);
            #1;
            budget++;
        end
        if (!req_ready) begin
            check("ready_timeout", 0, 1);
            req_valid = 1'b0;
            return;
        end
        in_rng = addr < DEPTH;
        e.sat  = 1'b0;
        e.rng  = rng;
        case (op)
            OP_WR: if (in_rng) model_mem[addr] = data;
            OP_ACC: begin
                if (in_rng) begin
                    sum = model_mem[addr] + data;
                    if (sum > 511) begin sum = 511; e.sat = 1'b1; end
                    else if (sum < -512) begin sum = -512; e.sat = 1'b1; end
                    model_mem[addr] = sum;
                    e.data = sum;
                end else begin
                    e.data = 0;
                end
                sb.push_back(e);
            end
            default: begin
                e.data = in_rng ? model_mem[addr] : 0;
                sb.push_back(e);
            end
        endcase
        @(negedge Clock);
        check("addr_err", int'(addr_err), int'(!in_rng));
        if (op == OP_ACC) begin
            check("acc_rd_valid_early", int'(rd_valid), 0);
            check("acc_ready_low", int'(req_ready), 0);
        end else if (op == OP_WR) begin
            check("wr_rd_valid", int'(rd_valid), 0);
        end else begin
            check("rd_latency", int'(rd_valid), 1);
        end
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) @(negedge Clock);
    endtask

    task automatic read_all(input bit rng);
        for (int i = 0; i < DEPTH; i++) send(OP_RD, i, 0, rng);
        idle(3);
    endtask

    initial begin
        Rst        = 1'b0;
        init_start = 1'b0;
        init_mode  = 1'b0;
        req_valid  = 1'b0;
        req_op     = OP_RD;
        req_addr   = '0;
        req_data   = '0;

        // Reset state.
        #3;
        check("rst_busy", int'(busy), 1);
        check("rst_ready", int'(req_ready), 0);
        check("rst_rd_valid", int'(rd_valid), 0);
        check("rst_rd_data", int'(rd_data), 0);
        check("rst_init_done", int'(init_done), 0);
        check("rst_flags", int'({sat_flag, addr_err}), 0);

        // Post-reset zero sweep.
        @(negedge Clock);
        @(negedge Clock);
        Rst = 1'b1;
        model_fill(1'b0);
        wait_init("boot");
        check("boot_ready", int'(req_ready), 1);
        send(OP_RD, 0, 0);
        send(OP_RD, 32, 0);
        send(OP_RD, 64, 0);
        idle(2);

        // Writes then back-to-back reads.
        send(OP_WR, 5, 37);
        send(OP_WR, 64, -200);
        send(OP_RD, 5, 0);
        send(OP_RD, 64, 0);
        idle(2);

        // Saturating accumulates, issued back to back.
        send(OP_WR, 3, 500);
        send(OP_WR, 4, -500);
        send(OP_WR, 6, 10);
        send(OP_ACC, 3, 20);
        send(OP_ACC, 4, -30);
        send(OP_ACC, 6, -3);
        idle(3);
        send(OP_RD, 3, 0);
        send(OP_RD, 4, 0);
        send(OP_RD, 6, 0);
        idle(2);

        // Random fill; a simultaneous read must not be accepted.
        init_start = 1'b1;
        init_mode  = 1'b1;
        req_valid  = 1'b1;
        req_op     = OP_RD;
        req_addr   = ADDR_W'(9);
        #1;
        check("init_prio_ready", int'(req_ready), 0);
        @(negedge Clock);
        init_start = 1'b0;
        req_valid  = 1'b0;
        check("init_prio_no_rd", int'(rd_valid), 0);
        model_fill(1'b1);
        wait_init("rand");
        read_all(1'b1);

        // Out-of-range accesses.
        send(OP_RD, 65, 0);
        send(OP_WR, 100, 77);
        send(OP_ACC, 127, 5);
        idle(3);
        send(OP_RD, 36, 0);
        send(OP_RD, 35, 0);
        send(OP_RD, 0, 0);
        send(OP_WR, 7, 123);
        send(OP_RD, 7, 0);
        idle(2);

        // Reset asserted at sweep address 30 of a random fill.
        init_start = 1'b1;
        init_mode  = 1'b1;
        @(negedge Clock);
        init_start = 1'b0;
        repeat (30) @(negedge Clock);
        Rst = 1'b0;
        #1;
        check("mid_rst_busy", int'(busy), 1);
        check("mid_rst_ready", int'(req_ready), 0);
        check("mid_rst_rd_data", int'(rd_data), 0);
        check("mid_rst_pulses", int'({rd_valid, init_done, sat_flag, addr_err}), 0);
        @(negedge Clock);
        @(negedge Clock);
        Rst = 1'b1;
        model_fill(1'b0);
        model_lfsr = 16'hACE1;
        wait_init("restart");
        read_all(1'b0);

        // LFSR is reseeded by reset: a new random fill repeats the seed sequence.
        init_start = 1'b1;
        init_mode  = 1'b1;
        @(negedge Clock);
        init_start = 1'b0;
        model_fill(1'b1);
        wait_init("reseed");
        read_all(1'b1);

        idle(4);
        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Overall time bound so the run always ends on its own.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1, "timeout");
    end

endmodule
